// File: rtl/ck2ck_fifo_reader.sv
// ---------------------------------------------------------------------------
// ck2ck_fifo_reader
//   Read-side engine of the clock-crossing FIFO. Lives entirely in the FIFO
//   read clock domain. Pops words from a show-ahead FIFO head and hands them,
//   in order, to a downstream valid/ready sink through a 2-entry buffer.
//   Optional burst pacing inserts a GAP_CYC-cycle pause after every BURST_LEN
//   pops. A flush pulse drops buffered data and drains the FIFO.
//
// Ports
//   ck         in   read-domain clock
//   arstN      in   asynchronous active-low reset
//   ena        in   level, 1 = stream FIFO contents downstream
//   flush      in   pulse, discard FIFO and buffered data
//   fifoData   in   FIFO head word (valid while fifoEmpty=0)
//   fifoEmpty  in   FIFO empty flag
//   fifoPop    out  combinational pop, head consumed at this rising edge
//   outData    out  downstream data (head of buffer)
//   outValid   out  downstream valid
//   outReady   in   downstream ready
//   busy       out  state != IDLE or buffer non-empty
//   status     out  0 IDLE, 1 STREAM, 2 GAP, 3 FLUSH
//   wordCnt    out  words delivered, wraps modulo 2^WCNT_W
// ---------------------------------------------------------------------------
module ck2ck_fifo_reader #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 16,
    parameter int GAP_CYC   = 0,
    parameter int WCNT_W    = 16
) (
    input  logic              ck,
    input  logic              arstN,
    input  logic              ena,
    input  logic              flush,
    input  logic [DATA_W-1:0] fifoData,
    input  logic              fifoEmpty,
    output logic              fifoPop,
    output logic [DATA_W-1:0] outData,
    output logic              outValid,
    input  logic              outReady,
    output logic              busy,
    output logic [1:0]        status,
    output logic [WCNT_W-1:0] wordCnt
);

    localparam int BURST_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   buf0_q, buf0_d;
    logic [DATA_W-1:0]   buf1_q, buf1_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    logic pop;          // FIFO head consumed this cycle
    logic push;         // popped word is kept in the buffer (STREAM only)
    logic xfer;         // downstream handshake completes this cycle
    logic enter_flush;

    always_comb begin
        pop         = 1'b0;
        push        = 1'b0;
        xfer        = (cnt_q != 2'd0) && outReady;
        enter_flush = flush && (state_q != ST_FLUSH);
        state_d     = state_q;
        burst_d     = burst_q;
        gap_d       = gap_q;

        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (ena) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // A pop that frees a slot via the same-cycle transfer is allowed
                // when the buffer is full; ena low or a flush stop new pops.
                push = ena && !flush && !fifoEmpty && ((cnt_q != 2'd2) || xfer);
                pop  = push;
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (!ena) begin
                    state_d = ST_IDLE;
                end else if (push) begin
                    if (burst_q == BURST_LAST) begin
                        burst_d = '0;
                        if (GAP_CYC > 0) begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ena ? ST_STREAM : ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                // Drain and discard; further flush pulses have no effect.
                pop = !fifoEmpty;
                if (fifoEmpty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_flush) begin
            burst_d = '0;
            gap_d   = '0;
        end
    end

    // Buffer: buf0 is the head, buf1 the tail.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d  = cnt_q;
        if (enter_flush) begin
            cnt_d = 2'd0;
        end else begin
            case ({push, xfer})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        buf0_d = fifoData;
                    end else begin
                        buf1_d = fifoData;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    buf0_d = buf1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    // Head leaves and a new word enters; occupancy unchanged.
                    if (cnt_q == 2'd1) begin
                        buf0_d = fifoData;
                    end else begin
                        buf0_d = buf1_q;
                        buf1_d = fifoData;
                    end
                end
                default: ;
            endcase
        end
    end

    // A transfer on the flush edge is dropped from the count.
    always_comb begin
        wcnt_d = wcnt_q;
        if (enter_flush) begin
            wcnt_d = '0;
        end else if (xfer) begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge ck or negedge arstN) begin
        if (!arstN) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            buf0_q  <= '0;
            burst_q <= '0;
            gap_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf0_q  <= buf0_d;
            burst_q <= burst_d;
            gap_q   <= gap_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Tail slot is only read once cnt_q says it holds a word.
    always_ff @(posedge ck) begin
        buf1_q <= buf1_d;
    end

    assign fifoPop  = arstN && pop;
    assign outData  = buf0_q;
    assign outValid = (cnt_q != 2'd0);
    assign busy     = arstN && ((state_q != ST_IDLE) || (cnt_q != 2'd0));
    assign status   = state_q;
    assign wordCnt  = wcnt_q;

endmodule

// File: tb/tb_ck2ck_fifo_reader.sv
// ---------------------------------------------------------------------------
// tb_ck2ck_fifo_reader
//   Directed bench for ck2ck_fifo_reader. Instance A uses the default pacing
//   (no gap); instance B uses BURST_LEN=4, GAP_CYC=3 and a 3-bit word counter
//   so that pacing and counter wrap are both exercised. Each instance is fed
//   from a show-ahead FIFO model held in a queue.
// ---------------------------------------------------------------------------
module tb_ck2ck_fifo_reader;

    logic        ck = 1'b0;
    logic        arstN;

    logic        ena_a, flush_a, fifoEmpty_a, fifoPop_a, outValid_a, outReady_a, busy_a;
    logic [15:0] fifoData_a, outData_a;
    logic [1:0]  status_a;
    logic [15:0] wordCnt_a;

    logic        ena_b, flush_b, fifoEmpty_b, fifoPop_b, outValid_b, outReady_b, busy_b;
    logic [15:0] fifoData_b, outData_b;
    logic [1:0]  status_b;
    logic [2:0]  wordCnt_b;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] rxa[$];
    logic [15:0] rxb[$];
    int          npa;
    int          npb;

    int checks = 0;
    int failures = 0;

    always #5 ck = ~ck;

    ck2ck_fifo_reader #(.DATA_W(16), .BURST_LEN(16), .GAP_CYC(0), .WCNT_W(16)) dut_a (
        .ck(ck), .arstN(arstN), .ena(ena_a), .flush(flush_a),
        .fifoData(fifoData_a), .fifoEmpty(fifoEmpty_a), .fifoPop(fifoPop_a),
        .outData(outData_a), .outValid(outValid_a), .outReady(outReady_a),
        .busy(busy_a), .status(status_a), .wordCnt(wordCnt_a)
    );

    ck2ck_fifo_reader #(.DATA_W(16), .BURST_LEN(4), .GAP_CYC(3), .WCNT_W(3)) dut_b (
        .ck(ck), .arstN(arstN), .ena(ena_b), .flush(flush_b),
        .fifoData(fifoData_b), .fifoEmpty(fifoEmpty_b), .fifoPop(fifoPop_b),
        .outData(outData_b), .outValid(outValid_b), .outReady(outReady_b),
        .busy(busy_b), .status(status_b), .wordCnt(wordCnt_b)
    );

    task automatic refresh();
        fifoEmpty_a = (qa.size() == 0);
        fifoData_a  = (qa.size() != 0) ? qa[0] : 16'h0;
        fifoEmpty_b = (qb.size() == 0);
        fifoData_b  = (qb.size() != 0) ? qb[0] : 16'h0;
    endtask

    // One clock: record pops/transfers at the negedge, apply pops to the FIFO
    // models just after the posedge, return at posedge+2.
    task automatic tick();
        logic        pa, pb;
        logic [15:0] tmp;
        @(negedge ck);
        pa = fifoPop_a;
        pb = fifoPop_b;
        if (outValid_a && outReady_a) rxa.push_back(outData_a);
        if (outValid_b && outReady_b) rxb.push_back(outData_b);
        @(posedge ck);
        #1;
        if (pa && qa.size() != 0) begin tmp = qa.pop_front(); npa++; end
        if (pb && qb.size() != 0) begin tmp = qb.pop_front(); npb++; end
        refresh();
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (outValid_a !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", outValid_a); end
        checks++; if (outData_a !== 16'h0) begin failures++; $display("FAIL reset_data: got %h expected 0000", outData_a); end
        checks++; if (status_a !== 2'd0) begin failures++; $display("FAIL reset_status: got %0d expected 0", status_a); end
        checks++; if (wordCnt_a !== 16'd0) begin failures++; $display("FAIL reset_wcnt: got %0d expected 0", wordCnt_a); end
        qa.push_back(16'h5555);
        refresh();
        ena_a = 1'b1;
        #1;
        checks++; if (fifoPop_a !== 1'b0) begin failures++; $display("FAIL reset_pop: got %0b expected 0", fifoPop_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy_a); end
        tick();
        checks++; if (status_a !== 2'd0) begin failures++; $display("FAIL reset_hold_status: got %0d expected 0", status_a); end
        ena_a = 1'b0;
        qa.delete();
        refresh();
        arstN = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 5; i++) qa.push_back(16'hA000 + 16'(i));
        refresh();
        rxa.delete();
        outReady_a = 1'b1;
        ena_a = 1'b1;
        tick();
        checks++; if (fifoPop_a !== 1'b1) begin failures++; $display("FAIL stream_first_pop: got %0b expected 1", fifoPop_a); end
        checks++; if (outValid_a !== 1'b0) begin failures++; $display("FAIL stream_latency_valid: got %0b expected 0", outValid_a); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (fifoPop_a !== 1'b1) begin failures++; $display("FAIL stream_pop[%0d]: got %0b expected 1", i, fifoPop_a); end
            tick();
        end
        checks++; if (fifoPop_a !== 1'b0) begin failures++; $display("FAIL stream_pop_empty: got %0b expected 0", fifoPop_a); end
        checks++; if (outData_a !== 16'hA004) begin failures++; $display("FAIL stream_last_data: got %h expected a004", outData_a); end
        tick();
        checks++; if (rxa.size() != 5) begin failures++; $display("FAIL stream_rx_count: got %0d expected 5", rxa.size()); end
        for (int i = 0; i < 5 && i < rxa.size(); i++) begin
            checks++; if (rxa[i] !== 16'hA000 + 16'(i)) begin failures++; $display("FAIL stream_rx[%0d]: got %h expected %h", i, rxa[i], 16'hA000 + 16'(i)); end
        end
        checks++; if (wordCnt_a !== 16'd5) begin failures++; $display("FAIL stream_wcnt: got %0d expected 5", wordCnt_a); end
        ena_a = 1'b0;
        tick();
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL stream_busy_end: got %0b expected 0", busy_a); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) qa.push_back(16'hB000 + 16'(i));
        refresh();
        rxa.delete();
        outReady_a = 1'b0;
        ena_a = 1'b1;
        tick();
        npa = 0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (npa != 2) begin failures++; $display("FAIL bp_pops: got %0d expected 2", npa); end
        checks++; if (fifoPop_a !== 1'b0) begin failures++; $display("FAIL bp_pop_stall: got %0b expected 0", fifoPop_a); end
        checks++; if (outValid_a !== 1'b1 || outData_a !== 16'hB000) begin failures++; $display("FAIL bp_head_hold: got %0b/%h expected 1/b000", outValid_a, outData_a); end
        outReady_a = 1'b1;
        #1;
        checks++; if (fifoPop_a !== 1'b1) begin failures++; $display("FAIL bp_pop_with_xfer: got %0b expected 1", fifoPop_a); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (rxa.size() != 4) begin failures++; $display("FAIL bp_rx_count: got %0d expected 4", rxa.size()); end
        for (int i = 0; i < 4 && i < rxa.size(); i++) begin
            checks++; if (rxa[i] !== 16'hB000 + 16'(i)) begin failures++; $display("FAIL bp_rx[%0d]: got %h expected %h", i, rxa[i], 16'hB000 + 16'(i)); end
        end
        checks++; if (wordCnt_a !== 16'd9) begin failures++; $display("FAIL bp_wcnt: got %0d expected 9", wordCnt_a); end
        ena_a = 1'b0;
        tick();
    endtask

    task automatic test_burst_gap();
        logic [16:0] exp_pop;
        logic [16:0] exp_gap;
        logic [1:0]  exp_st;
        exp_pop = 17'b0_1100_0111_1000_1111;
        exp_gap = 17'b0_0011_1000_0111_0000;
        for (int i = 0; i < 10; i++) qb.push_back(16'hC000 + 16'(i));
        refresh();
        rxb.delete();
        outReady_b = 1'b1;
        ena_b = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            exp_st = exp_gap[i] ? 2'd2 : 2'd1;
            checks++; if (status_b !== exp_st) begin failures++; $display("FAIL burst_status[%0d]: got %0d expected %0d", i, status_b, exp_st); end
            checks++; if (fifoPop_b !== exp_pop[i]) begin failures++; $display("FAIL burst_pop[%0d]: got %0b expected %0b", i, fifoPop_b, exp_pop[i]); end
            tick();
        end
        tick();
        checks++; if (rxb.size() != 10) begin failures++; $display("FAIL burst_rx_count: got %0d expected 10", rxb.size()); end
        for (int i = 0; i < 10 && i < rxb.size(); i++) begin
            checks++; if (rxb[i] !== 16'hC000 + 16'(i)) begin failures++; $display("FAIL burst_rx[%0d]: got %h expected %h", i, rxb[i], 16'hC000 + 16'(i)); end
        end
        checks++; if (wordCnt_b !== 3'd2) begin failures++; $display("FAIL burst_wcnt_wrap: got %0d expected 2", wordCnt_b); end
        ena_b = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 8; i++) qa.push_back(16'hD000 + 16'(i));
        refresh();
        rxa.delete();
        outReady_a = 1'b0;
        ena_a = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (outValid_a !== 1'b1 || qa.size() != 6) begin failures++; $display("FAIL flush_setup: got valid %0b fifo %0d expected 1/6", outValid_a, qa.size()); end
        flush_a = 1'b1;
        ena_a = 1'b0;
        tick();
        flush_a = 1'b0;
        checks++; if (outValid_a !== 1'b0) begin failures++; $display("FAIL flush_valid: got %0b expected 0", outValid_a); end
        checks++; if (wordCnt_a !== 16'd0) begin failures++; $display("FAIL flush_wcnt: got %0d expected 0", wordCnt_a); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (status_a !== 2'd3 || fifoPop_a !== 1'b1) begin failures++; $display("FAIL flush_drain[%0d]: got status %0d pop %0b expected 3/1", i, status_a, fifoPop_a); end
            if (i == 2) flush_a = 1'b1;
            tick();
            flush_a = 1'b0;
        end
        checks++; if (status_a !== 2'd3 || fifoPop_a !== 1'b0) begin failures++; $display("FAIL flush_empty: got status %0d pop %0b expected 3/0", status_a, fifoPop_a); end
        tick();
        checks++; if (status_a !== 2'd0) begin failures++; $display("FAIL flush_exit: got %0d expected 0", status_a); end
        checks++; if (busy_a !== 1'b0 || rxa.size() != 0) begin failures++; $display("FAIL flush_discard: got busy %0b rx %0d expected 0/0", busy_a, rxa.size()); end
    endtask

    task automatic test_ena_drop();
        for (int i = 0; i < 6; i++) qa.push_back(16'hE000 + 16'(i));
        refresh();
        rxa.delete();
        outReady_a = 1'b0;
        ena_a = 1'b1;
        tick();
        tick();
        tick();
        ena_a = 1'b0;
        outReady_a = 1'b1;
        npa = 0;
        #1;
        checks++; if (fifoPop_a !== 1'b0) begin failures++; $display("FAIL enadrop_pop: got %0b expected 0", fifoPop_a); end
        tick();
        checks++; if (status_a !== 2'd0) begin failures++; $display("FAIL enadrop_status: got %0d expected 0", status_a); end
        checks++; if (busy_a !== 1'b1 || outData_a !== 16'hE001) begin failures++; $display("FAIL enadrop_second: got busy %0b data %h expected 1/e001", busy_a, outData_a); end
        tick();
        checks++; if (busy_a !== 1'b0 || outValid_a !== 1'b0) begin failures++; $display("FAIL enadrop_busy: got busy %0b valid %0b expected 0/0", busy_a, outValid_a); end
        checks++; if (npa != 0 || qa.size() != 4) begin failures++; $display("FAIL enadrop_nopop: got pops %0d fifo %0d expected 0/4", npa, qa.size()); end
        checks++; if (rxa.size() != 2 || wordCnt_a !== 16'd2) begin failures++; $display("FAIL enadrop_rx: got rx %0d wcnt %0d expected 2/2", rxa.size(), wordCnt_a); end
        for (int i = 0; i < 2 && i < rxa.size(); i++) begin
            checks++; if (rxa[i] !== 16'hE000 + 16'(i)) begin failures++; $display("FAIL enadrop_rx[%0d]: got %h expected %h", i, rxa[i], 16'hE000 + 16'(i)); end
        end
    endtask

    task automatic test_reset_mid_stream();
        outReady_a = 1'b0;
        ena_a = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (outValid_a !== 1'b1 || wordCnt_a !== 16'd2) begin failures++; $display("FAIL rstmid_setup: got valid %0b wcnt %0d expected 1/2", outValid_a, wordCnt_a); end
        #2;
        arstN = 1'b0;
        #1;
        checks++; if (outValid_a !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %0b expected 0", outValid_a); end
        checks++; if (status_a !== 2'd0) begin failures++; $display("FAIL rstmid_status: got %0d expected 0", status_a); end
        checks++; if (wordCnt_a !== 16'd0) begin failures++; $display("FAIL rstmid_wcnt: got %0d expected 0", wordCnt_a); end
        checks++; if (fifoPop_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL rstmid_pop_busy: got %0b/%0b expected 0/0", fifoPop_a, busy_a); end
        checks++; if (outData_a !== 16'h0) begin failures++; $display("FAIL rstmid_data: got %h expected 0000", outData_a); end
        ena_a = 1'b0;
        qa.delete();
        refresh();
        @(negedge ck);
        arstN = 1'b1;
        tick();
        checks++; if (status_a !== 2'd0 || outValid_a !== 1'b0) begin failures++; $display("FAIL rstmid_after: got status %0d valid %0b expected 0/0", status_a, outValid_a); end
    endtask

    initial begin
        arstN = 1'b0;
        ena_a = 1'b0; flush_a = 1'b0; outReady_a = 1'b0;
        ena_b = 1'b0; flush_b = 1'b0; outReady_b = 1'b0;
        npa = 0; npb = 0;
        refresh();
        test_reset();
        test_stream();
        test_backpressure();
        test_burst_gap();
        test_flush();
        test_ena_drop();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
